seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed N-digit seven-segment display driver. A packed BCD word is
// captured into a display latch and the digits are scanned one at a time. Each
// digit stays active for SCAN_DIV clock cycles. The segment lines are shared by
// all digits, and each digit has its own enable line.
//
// Parameters:
//   N_DIGITS  number of digits scanned (1..8)
//   SCAN_DIV  clk cycles each digit is held active (>= 1)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous, active-high reset
//   bcd_in      packed BCD; digit i is bcd_in[4i+3:4i], digit 0 is rightmost
//   load        captures bcd_in into the display latch at the clock edge
//   blank       forces every digit dark; scanning keeps running underneath
//   seg         {a,b,c,d,e,f,g}, active-low, registered
//   an          digit enables, active-low one-hot, registered
//   frame_done  one-cycle pulse after the last digit's scan period ends
//
// Build option:
//   LEADING_ZERO_SUPPRESS_EN  when defined, leading zero digits are dark.
//                             Digit 0 is always shown.
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic                    load,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    // Counter widths are kept at least 1 bit so that the degenerate
    // configurations (SCAN_DIV=1, N_DIGITS=1) still elaborate.
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [6:0]    SEG_DARK   = 7'h7F;

    logic [PW-1:0]           prescaler;
    logic [DW-1:0]           digit_sel;
    logic [4*N_DIGITS-1:0]   latch;
    logic                    tick;
    logic [3:0]              nibble;
    logic                    digit_dark;
    logic [6:0]              seg_next;
    logic [N_DIGITS-1:0]     an_next;

    // BCD to active-low segment code {a,b,c,d,e,f,g}. Codes 10..15 are not
    // valid BCD, so the digit is left dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h01;
            4'd1:    code = 7'h4F;
            4'd2:    code = 7'h12;
            4'd3:    code = 7'h06;
            4'd4:    code = 7'h4C;
            4'd5:    code = 7'h24;
            4'd6:    code = 7'h20;
            4'd7:    code = 7'h0F;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h04;
            default: code = SEG_DARK;
        endcase
        return code;
    endfunction

    assign tick = (prescaler == PRESC_LAST);

    // Select the nibble of the current digit and build the one-hot enable.
    always_comb begin
        nibble  = '0;
        an_next = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (digit_sel == DW'(i)) begin
                nibble     = latch[4*i +: 4];
                an_next[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    // Digit i (i > 0) is a leading zero when the latch, shifted right so that
    // digit i is the lowest digit, is all zero. This covers digits N_DIGITS-1
    // down to i. Digit 0 is never suppressed, so an all-zero value still
    // shows "0".
    logic [N_DIGITS-1:0] lz_mask;

    always_comb begin
        lz_mask = '0;
        for (int unsigned i = 1; i < N_DIGITS; i++) begin
            lz_mask[i] = ((latch >> (4*i)) == '0);
        end
    end

    always_comb begin
        digit_dark = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (digit_sel == DW'(i)) begin
                digit_dark = lz_mask[i];
            end
        end
    end
`else
    assign digit_dark = 1'b0;
`endif

    // Blank darkens both the segments and the enables. A suppressed or
    // illegal digit darkens only the segments, and its enable stays asserted.
    always_comb begin
        seg_next = bcd_to_seg(nibble);
        if (digit_dark) begin
            seg_next = SEG_DARK;
        end
        if (blank) begin
            seg_next = SEG_DARK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            digit_sel  <= '0;
            latch      <= '0;
            seg        <= SEG_DARK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                if (digit_sel == DIGIT_LAST) begin
                    digit_sel <= '0;
                end else begin
                    digit_sel <= digit_sel + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (load) begin
                latch <= bcd_in;
            end

            frame_done <= tick && (digit_sel == DIGIT_LAST);

            // The output registers sample the pre-edge digit_sel and latch.
            // This gives a 1-cycle delay from select to display and a
            // 2-edge delay from load to display.
            seg <= seg_next;
            an  <= blank ? '1 : an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Directed bench for seven_seg_scan_driver. Two instances are used:
//   dut       N_DIGITS=4, SCAN_DIV=4
//   dut_fast  N_DIGITS=4, SCAN_DIV=1
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge. Edge n counts the rising edges after rst is released
// (edge 1 is the first edge with rst low).
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, blank;
    logic [15:0] bcd_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    logic        rst_f, load_f, blank_f;
    logic [15:0] bcd_f;
    logic [6:0]  seg_f;
    logic [3:0]  an_f;
    logic        frame_done_f;

    int total = 0;
    int bad   = 0;

    seven_seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank(blank),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    seven_seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(1)) dut_fast (
        .clk(clk), .rst(rst_f), .bcd_in(bcd_f), .load(load_f), .blank(blank_f),
        .seg(seg_f), .an(an_f), .frame_done(frame_done_f)
    );

    // Hand-entered segment table (abc_defg, active-low).
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h04;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {seg, an, frame_done} when digit d of val is on display.
    function automatic logic [11:0] expect_vec(input logic [15:0] val, input int d, input logic fd);
        logic [15:0] t;
        logic [3:0]  a;
        t    = val >> (4*d);
        a    = 4'b1111;
        a[d] = 1'b0;
        return {seg_code(t[3:0]), a, fd};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold c=%0d got seg=%h an=%b fd=%b want seg=7f an=1111 fd=0",
                         c, seg, an, frame_done);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp = expect_vec(16'h0000, ((n-1)/4) % 4, (n % 16) == 0);
            total++;
            if ({seg, an, frame_done} !== exp) begin
                bad++;
                $display("FAIL reset_scan n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
            end
        end
    endtask

    task automatic test_scan();
        logic [11:0] exp;
        do_reset();
        load = 1'b1; bcd_in = 16'h1234;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n == 1) exp = expect_vec(16'h0000, 0, 1'b0);
            else        exp = expect_vec(16'h1234, ((n-1)/4) % 4, (n % 16) == 0);
            total++;
            if ({seg, an, frame_done} !== exp) begin
                bad++;
                $display("FAIL scan n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
            end
            if (n == 1) load = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic [11:0] exp;
        do_reset();
        load = 1'b1; bcd_in = 16'hA9F0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) exp = expect_vec(16'h0000, 0, 1'b0);
            else        exp = expect_vec(16'hA9F0, ((n-1)/4) % 4, (n % 16) == 0);
            total++;
            if ({seg, an, frame_done} !== exp) begin
                bad++;
                $display("FAIL illegal n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
            end
            if (n == 1) load = 1'b0;
        end
    endtask

    // blank is high for edges 1..10, and 8888 is loaded on edge 5.
    // Scanning continues underneath, so edge 11 shows digit 2.
    task automatic test_blank();
        logic [11:0] exp;
        do_reset();
        blank = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n <= 10) exp = {7'h7F, 4'hF, 1'b0};
            else         exp = expect_vec(16'h8888, ((n-1)/4) % 4, (n % 16) == 0);
            total++;
            if ({seg, an, frame_done} !== exp) begin
                bad++;
                $display("FAIL blank n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
            end
            if (n == 4)  begin load = 1'b1; bcd_in = 16'h8888; end
            if (n == 5)  load  = 1'b0;
            if (n == 10) blank = 1'b0;
        end
    endtask

    // The second load lands on edge 4, which is also a tick edge.
    task automatic test_load_tick();
        logic [11:0] exp;
        logic [15:0] val;
        do_reset();
        load = 1'b1; bcd_in = 16'h1234;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            val = (n <= 1) ? 16'h0000 : ((n <= 4) ? 16'h1234 : 16'h5678);
            exp = expect_vec(val, ((n-1)/4) % 4, (n % 16) == 0);
            total++;
            if ({seg, an, frame_done} !== exp) begin
                bad++;
                $display("FAIL load_tick n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
            end
            if (n == 1) load = 1'b0;
            if (n == 3) begin load = 1'b1; bcd_in = 16'h5678; end
            if (n == 4) load = 1'b0;
        end
    endtask

    task automatic test_fast_reset();
        logic [11:0] exp;
        @(negedge clk);
        rst_f = 1'b0; load_f = 1'b1; bcd_f = 16'h4321; blank_f = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) exp = expect_vec(16'h0000, 0, 1'b0);
            else        exp = expect_vec(16'h4321, (n-1) % 4, 1'b0);
            total++;
            if ({seg_f, an_f, frame_done_f} !== exp) begin
                bad++;
                $display("FAIL fast_pre n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg_f, an_f, frame_done_f, exp[11:5], exp[4:1], exp[0]);
            end
        end
        rst_f = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({seg_f, an_f, frame_done_f} !== {7'h7F, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL fast_mid_reset c=%0d got seg=%h an=%b fd=%b want seg=7f an=1111 fd=0",
                         c, seg_f, an_f, frame_done_f);
            end
        end
        rst_f = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) exp = expect_vec(16'h0000, 0, 1'b0);
            else        exp = expect_vec(16'h4321, (n-1) % 4, (n % 4) == 0);
            total++;
            if ({seg_f, an_f, frame_done_f} !== exp) begin
                bad++;
                $display("FAIL fast_scan n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         n, seg_f, an_f, frame_done_f, exp[11:5], exp[4:1], exp[0]);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [11:0] exp;
        logic [15:0] vals [2];
        logic [15:0] hi;
        int          d;
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            load = 1'b1; bcd_in = vals[v];
            for (int n = 1; n <= 16; n++) begin
                @(negedge clk);
                if (n == 1) load = 1'b0;
                if (n >= 2) begin
                    d   = ((n-1)/4) % 4;
                    exp = expect_vec(vals[v], d, (n % 16) == 0);
`ifdef LEADING_ZERO_SUPPRESS_EN
                    hi = vals[v] >> (4*d);
                    if (d > 0 && hi == 16'h0000) exp[11:5] = 7'h7F;
`else
                    hi = '0;
`endif
                    total++;
                    if ({seg, an, frame_done} !== exp) begin
                        bad++;
                        $display("FAIL lead_zero val=%h n=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                                 vals[v], n, seg, an, frame_done, exp[11:5], exp[4:1], exp[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0;
        rst_f = 1'b1; load_f = 1'b0; blank_f = 1'b0; bcd_f = '0;
        test_reset();
        test_scan();
        test_illegal();
        test_blank();
        test_load_tick();
        test_fast_reset();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
